// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state, line frame type and sizing constants for the data cache
package cache_pkg;
  localparam int OFF_W = 2;
  localparam int DEF_SETS = 16;
  localparam int TAG_MAX = 30;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } dcache_state_t;
  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        data;
  } dcache_frame_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped frame storage, async read, one sync write, invalidate-all on RST
module dcache_array
  import cache_pkg::*;
#(
  parameter int SETS = DEF_SETS
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [$clog2(SETS)-1:0] ridx,
  output dcache_frame_t           rframe,
  input  logic                    we,
  input  logic [$clog2(SETS)-1:0] widx,
  input  dcache_frame_t           wframe
);
  logic [SETS-1:0]    valid;
  logic [TAG_MAX-1:0] mem_tag  [SETS];
  logic [31:0]        mem_data [SETS];

  assign rframe = '{valid: valid[ridx], tag: mem_tag[ridx], data: mem_data[ridx]};

  // valid bits are the only reset state; reset beats a same-cycle write
  always_ff @(posedge CLK)
    if (RST) valid <= '0;
    else if (we) valid[widx] <= wframe.valid;

  // tag and data carry no reset, they are meaningless while invalid
  always_ff @(posedge CLK)
    if (we) begin
      mem_tag[widx]  <= wframe.tag;
      mem_data[widx] <= wframe.data;
    end
endmodule

// File: rtl/dcache_responder.sv
// dcache_responder: direct-mapped write-through no-allocate dcache; DCACHE_STATS_EN adds hit/miss counters
module dcache_responder
  import cache_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic              dhit,
  output logic [31:0]       dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic              ramwait
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WA_W  = ADDR_W - OFF_W;

  dcache_state_t      state;
  logic [WA_W-1:0]    req_addr;
  logic [31:0]        req_data;
  logic [IDX_W-1:0]   ridx;
  logic [TAG_MAX-1:0] d_tag;
  logic [TAG_MAX-1:0] req_tag;
  dcache_frame_t      rframe;
  dcache_frame_t      wframe;
  logic               we;
  logic               tag_ok;
  logic               rd_hit;
  logic               rd_miss;
  logic               fill_done;
  logic               wr_done;
  logic               unused_ok;

  assign unused_ok = ^daddr[OFF_W-1:0];
  assign d_tag     = TAG_MAX'(daddr[ADDR_W-1:OFF_W+IDX_W]);
  assign req_tag   = TAG_MAX'(req_addr[WA_W-1:IDX_W]);

  dcache_array #(.SETS(SETS)) u_array (
    .CLK   (CLK),
    .RST   (RST),
    .ridx  (ridx),
    .rframe(rframe),
    .we    (we),
    .widx  (req_addr[IDX_W-1:0]),
    .wframe(wframe)
  );

  // IDLE looks up the live request; WRITE looks up the latched one to decide on a write-hit update
  always_comb begin
    ridx      = state == IDLE ? daddr[OFF_W+IDX_W-1:OFF_W] : req_addr[IDX_W-1:0];
    tag_ok    = rframe.valid && rframe.tag == (state == IDLE ? d_tag : req_tag);
    rd_hit    = state == IDLE && dREN && !dWEN && tag_ok;
    rd_miss   = state == IDLE && dREN && !dWEN && !tag_ok;
    fill_done = state == FILL && !ramwait;
    wr_done   = state == WRITE && !ramwait;
    dhit      = rd_hit || wr_done;
    dload     = rd_hit ? rframe.data : '0;
    ramREN    = state == FILL;
    ramWEN    = state == WRITE;
    ramaddr   = state != IDLE ? {req_addr, {OFF_W{1'b0}}} : '0;
    ramstore  = state == WRITE ? req_data : '0;
    we        = fill_done || (wr_done && tag_ok);
    wframe    = '{valid: 1'b1, tag: req_tag, data: fill_done ? ramload : req_data};
  end

  // request FSM; writes win over reads, address and data are frozen for the whole access
  always_ff @(posedge CLK)
    if (RST) begin
      state    <= IDLE;
      req_addr <= '0;
      req_data <= '0;
    end else
      case (state)
        IDLE:
          if (dWEN) begin
            state    <= WRITE;
            req_addr <= daddr[ADDR_W-1:OFF_W];
            req_data <= dstore;
          end else if (rd_miss) begin
            state    <= FILL;
            req_addr <= daddr[ADDR_W-1:OFF_W];
          end
        FILL, WRITE: if (!ramwait) state <= IDLE;
        default: state <= IDLE;
      endcase

`ifdef DCACHE_STATS_EN
  // saturating counters of read hits and of read misses entering FILL
  always_ff @(posedge CLK)
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && ~&hit_count) hit_count <= hit_count + 1'b1;
      if (rd_miss && ~&miss_count) miss_count <= miss_count + 1'b1;
    end
`endif
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Datapath-facing data cache that answers the dREN/dWEN request pulses raised by the request unit.
- Returns dhit and dload, and fetches from or writes to memory through a ram-side port.
- Direct-mapped, one word per line, write-through, no-allocate on write.
- Sits between the datapath request logic and the memory controller or arbiter.

Parameters:
SETS, 16, number of lines; power of two, minimum 2
ADDR_W, 32, byte address width; index = log2(SETS) bits above the 2 offset bits; tag = ADDR_W-2-log2(SETS)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
dREN  in  1  data read request, held until dhit
dWEN  in  1  data write request, held until dhit
daddr  in  ADDR_W  byte address; bits [1:0] ignored
dstore  in  32  write data
dhit  out  1  single-cycle completion pulse for the current request
dload  out  32  read data, valid while dhit=1 on a read
ramREN  out  1  memory read strobe
ramWEN  out  1  memory write strobe
ramaddr  out  ADDR_W  memory word address, bits [1:0] forced to 0
ramstore  out  32  memory write data
ramload  in  32  memory read data, valid when ramwait=0
ramwait  in  1  memory busy; 0 = current ramREN/ramWEN access completes this cycle

Behaviour:
- Reset: synchronous on RST=1. FSM goes to IDLE and all valid bits clear. dhit=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, dload=0.
- States: IDLE, FILL, WRITE. Frame per line: valid, tag, 32-bit data.
- IDLE, dREN=1, dWEN=0, line valid and tag match (hit):
  - dhit=1 combinationally in the same cycle; dload = line data.
  - Stay IDLE.
- IDLE, dREN=1, miss:
  - dhit=0.
  - Latch the word address into a request register; next state FILL.
- FILL:
  - Drive ramREN=1 and ramaddr = latched address.
  - When ramwait=0: write ramload and the tag into the line, set valid, go to IDLE.
  - The next IDLE cycle re-looks-up and hits, so dhit comes the cycle after the fill.
  - Minimum read-miss latency is 3 cycles.
- IDLE, dWEN=1:
  - Latch address and dstore; next state WRITE. dREN is ignored when dWEN=1, so write has priority.
- WRITE:
  - Drive ramWEN=1, ramaddr = latched address, ramstore = latched data.
  - When ramwait=0: dhit=1 that cycle and go to IDLE.
  - If the indexed line is valid with matching tag, update its data with the latched value in the same cycle.
  - On a tag miss, no allocation.
- ramREN and ramWEN are never asserted together. Both are Moore outputs of the FILL/WRITE states.
- dhit is high for exactly one cycle per request. The requester drops dREN/dWEN on the edge after dhit, so IDLE never double-services a request.
- The latched address and data are used throughout FILL and WRITE. Changes on daddr or dstore mid-access are ignored.
- ramwait held high: stay in FILL/WRITE indefinitely with strobes held, no timeout.
- RST mid-FILL or mid-WRITE: strobes drop on the next edge and no partial line is written.
- Index wrap: index = daddr[log2(SETS)+1:2]; aliasing addresses evict by tag replacement on fill.
- dload = 0 whenever dhit=0.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments on each read hit dhit pulse.
  - miss_count increments on each IDLE->FILL transition.
  - Both clear on RST and saturate at 32'hFFFFFFFF. Writes are not counted.
- When undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg:
  - enum dcache_state_t {IDLE, FILL, WRITE}.
  - struct dcache_frame_t {valid, tag, data}.
  - Constants for word offset width (2) and default SETS.
- One sub-module, dcache_array: frame storage with combinational read port and single synchronous write port, invalidate-all on RST.
- FSM and control stay in dcache_responder.

Test Plan:
- Reset then dREN=1, daddr=0x100, ramwait=0, ramload=0xDEADBEEF -> ramREN=1 for 1 cycle, dhit=1 with dload=0xDEADBEEF on cycle 3, ramREN=0.
- Repeat dREN at 0x100 -> dhit=1 in the same cycle, ramREN never asserted.
- dWEN=1, daddr=0x100, dstore=0x12345678, ramwait=1 for 4 cycles -> ramWEN=1 and ramstore=0x12345678 held for 5 cycles, dhit on the 5th; subsequent read of 0x100 hits with 0x12345678.
- Write to uncached 0x200 -> ramWEN cycle and dhit; then read 0x200 -> miss with ramREN asserted (no-allocate).
- Alias: fill 0x100, then read 0x100+4*SETS=0x140 -> miss and fill; then read 0x100 -> miss again.
- RST during FILL with ramwait=1 -> ramREN=0 after the edge; read of same address misses afterwards. With DCACHE_STATS_EN: two misses, one hit -> miss_count=2, hit_count=1.
